// File: rtl/count_hex_display.sv
// ---------------------------------------------------------------------------
// count_hex_display
//
// Converts an unsigned binary count to four BCD digits with an iterative
// double-dabble FSM and drives four active-low seven-segment displays.
// A conversion starts automatically whenever the input value or the
// blanking mode differs from the last converted pair (or after reset).
// The HEX outputs only change when a conversion completes, so a partially
// converted number is never shown.
//
// Ports
//   CLOCK_50  in   1      board clock, rising-edge active
//   Resetn    in   1      asynchronous active-low reset
//   value     in   WIDTH  unsigned binary count
//   blank_lz  in   1      1 = blank leading zeros (units digit always shown)
//   HEX0..3   out  7      units..thousands, active-low, bit0=a .. bit6=g
//   busy      out  1      high while a conversion is in progress
//   done      out  1      one-cycle pulse on the cycle HEX outputs update
// ---------------------------------------------------------------------------
module count_hex_display #(
    parameter int WIDTH  = 10,   // 1..13 so four decimal digits suffice
    parameter int DIGITS = 4     // fixed at 4 displays
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] value,
    input  logic             blank_lz,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic             busy,
    output logic             done
);

    localparam int              BCDW = 4 * DIGITS;
    localparam int              CW   = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
    localparam logic [6:0]      SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [BCDW-1:0]    bcd_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   shadow_val_q;
    logic               shadow_lz_q;
    logic               valid_q;
    logic [6:0]         hex_q [DIGITS];
    logic               busy_q;
    logic               done_q;

    logic [BCDW-1:0]    bcd_adj_d;
    logic [6:0]         seg_d [DIGITS];
    logic               blank_d [DIGITS];
    logic               need_conv_d;

    // Active-low segment pattern for one BCD digit; non-decimal codes blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift so
    // that the doubling carries correctly into the next decimal digit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj_d[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5)
                                        ? bcd_q[4*gi +: 4] + 4'd3
                                        : bcd_q[4*gi +: 4];
        end
    endgenerate

    // Leading-zero blanking: a digit blanks only if it and every more
    // significant digit are zero. The units digit is never blanked.
    logic zero3, zero32, zero321;
    assign zero3   = (bcd_q[15:12] == 4'd0);
    assign zero32  = zero3  && (bcd_q[11:8] == 4'd0);
    assign zero321 = zero32 && (bcd_q[7:4]  == 4'd0);

    assign blank_d[0] = 1'b0;
    assign blank_d[1] = shadow_lz_q && zero321;
    assign blank_d[2] = shadow_lz_q && zero32;
    assign blank_d[3] = shadow_lz_q && zero3;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
            assign seg_d[gi] = blank_d[gi] ? SEG_BLANK : seg7(bcd_q[4*gi +: 4]);
        end
    endgenerate

    assign need_conv_d = !valid_q || (value != shadow_val_q)
                                  || (blank_lz != shadow_lz_q);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            shadow_val_q <= '0;
            shadow_lz_q  <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < DIGITS; i++) hex_q[i] <= SEG_BLANK;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (need_conv_d) begin
                        shift_q      <= value;
                        shadow_val_q <= value;
                        shadow_lz_q  <= blank_lz;
                        bcd_q        <= '0;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, shift_q} <= {bcd_adj_d, shift_q} << 1;
                    cnt_q            <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= UPDATE;
                end
                UPDATE: begin
                    for (int i = 0; i < DIGITS; i++) hex_q[i] <= seg_d[i];
                    valid_q <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_count_hex_display.sv
// Testbench for count_hex_display: table-driven conversions plus
// hand-written sequences for reset, mid-conversion changes and stability.
module tb_count_hex_display;

    localparam int WIDTH = 10;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] value;
    logic             blank_lz;
    logic [6:0]       hex0, hex1, hex2, hex3;
    logic             busy, done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    count_hex_display #(.WIDTH(WIDTH), .DIGITS(4)) dut (
        .CLOCK_50 (clk),
        .Resetn   (rst_n),
        .value    (value),
        .blank_lz (blank_lz),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic [WIDTH-1:0] v;
        logic             lz;
        logic [6:0]       h3, h2, h1, h0;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs already applied just after a negedge with the DUT idle.
    // Checks capture-to-done latency, busy length, HEX values and done fall.
    task automatic run_conv(input string name, input logic [6:0] e3, e2, e1, e0);
        int k;
        int busy_n;
        busy_n = 0;
        @(posedge clk);
        for (k = 0; k <= WIDTH + 4; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) break;
        end
        chk({name, "_latency"}, k, WIDTH + 1);
        chk({name, "_busy_len"}, busy_n, WIDTH + 1);
        chk({name, "_hex3"}, {25'd0, hex3}, {25'd0, e3});
        chk({name, "_hex2"}, {25'd0, hex2}, {25'd0, e2});
        chk({name, "_hex1"}, {25'd0, hex1}, {25'd0, e1});
        chk({name, "_hex0"}, {25'd0, hex0}, {25'd0, e0});
        @(negedge clk);
        chk({name, "_done_fall"}, {31'd0, done}, 32'd0);
        $display("conv %s value=%0d lz=%0b hex3..0=%h %h %h %h", name, value, blank_lz,
                 hex3, hex2, hex1, hex0);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done !== 1'b1 && k < 40);
        if (done !== 1'b1) k = -1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int base;

        tbl[0]  = '{10'd1023, 1'b0, 7'h79, 7'h40, 7'h24, 7'h30};
        tbl[1]  = '{10'd987,  1'b1, 7'h7F, 7'h10, 7'h00, 7'h78};
        tbl[2]  = '{10'd40,   1'b1, 7'h7F, 7'h7F, 7'h19, 7'h40};
        tbl[3]  = '{10'd40,   1'b0, 7'h40, 7'h40, 7'h19, 7'h40};
        tbl[4]  = '{10'd5,    1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h12};
        tbl[5]  = '{10'd100,  1'b1, 7'h7F, 7'h79, 7'h40, 7'h40};
        tbl[6]  = '{10'd1000, 1'b1, 7'h79, 7'h40, 7'h40, 7'h40};
        tbl[7]  = '{10'd506,  1'b0, 7'h40, 7'h12, 7'h40, 7'h02};
        tbl[8]  = '{10'd64,   1'b1, 7'h7F, 7'h7F, 7'h02, 7'h19};
        tbl[9]  = '{10'd999,  1'b1, 7'h7F, 7'h10, 7'h10, 7'h10};
        tbl[10] = '{10'd512,  1'b1, 7'h7F, 7'h12, 7'h79, 7'h24};
        tbl[11] = '{10'd7,    1'b0, 7'h40, 7'h40, 7'h40, 7'h78};
        tbl[12] = '{10'd10,   1'b1, 7'h7F, 7'h7F, 7'h79, 7'h40};
        tbl[13] = '{10'd683,  1'b1, 7'h7F, 7'h02, 7'h00, 7'h30};

        // Reset state
        rst_n    = 1'b0;
        value    = '0;
        blank_lz = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hex0", {25'd0, hex0}, 32'h7F);
        chk("rst_hex1", {25'd0, hex1}, 32'h7F);
        chk("rst_hex2", {25'd0, hex2}, 32'h7F);
        chk("rst_hex3", {25'd0, hex3}, 32'h7F);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Release with value 0: first edge captures
        base  = done_cnt;
        rst_n = 1'b1;
        run_conv("release_zero", 7'h7F, 7'h7F, 7'h7F, 7'h40);
        chk("release_one_done", done_cnt - base, 1);

        // Table-driven conversions
        for (int i = 0; i < 14; i++) begin
            value    = tbl[i].v;
            blank_lz = tbl[i].lz;
            run_conv($sformatf("vec%0d", i), tbl[i].h3, tbl[i].h2, tbl[i].h1, tbl[i].h0);
        end

        // Change during conversion: 5 then 987 three cycles after capture
        base     = done_cnt;
        value    = 10'd5;
        blank_lz = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        value = 10'd987;
        wait_done(k);
        chk("chg_first_latency", k, 8);
        chk("chg_first_hex3", {25'd0, hex3}, 32'h7F);
        chk("chg_first_hex2", {25'd0, hex2}, 32'h7F);
        chk("chg_first_hex1", {25'd0, hex1}, 32'h7F);
        chk("chg_first_hex0", {25'd0, hex0}, 32'h12);
        $display("conv chg_first value=5 hex3..0=%h %h %h %h", hex3, hex2, hex1, hex0);
        wait_done(k);
        chk("chg_second_latency", k, WIDTH + 2);
        chk("chg_second_hex3", {25'd0, hex3}, 32'h7F);
        chk("chg_second_hex2", {25'd0, hex2}, 32'h10);
        chk("chg_second_hex1", {25'd0, hex1}, 32'h00);
        chk("chg_second_hex0", {25'd0, hex0}, 32'h78);
        $display("conv chg_second value=987 hex3..0=%h %h %h %h", hex3, hex2, hex1, hex0);
        repeat (20) @(negedge clk);
        chk("chg_two_dones", done_cnt - base, 2);

        // Stability then blanking toggle
        value    = 10'd40;
        blank_lz = 1'b1;
        run_conv("hold40", 7'h7F, 7'h7F, 7'h19, 7'h40);
        base = done_cnt;
        repeat (100) @(negedge clk);
        chk("hold_no_done", done_cnt - base, 0);
        chk("hold_not_busy", {31'd0, busy}, 32'd0);
        blank_lz = 1'b0;
        run_conv("lz_toggle", 7'h40, 7'h40, 7'h19, 7'h40);

        // Reset mid-conversion of 512
        value    = 10'd512;
        blank_lz = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hex0", {25'd0, hex0}, 32'h7F);
        chk("mid_rst_hex1", {25'd0, hex1}, 32'h7F);
        chk("mid_rst_hex2", {25'd0, hex2}, 32'h7F);
        chk("mid_rst_hex3", {25'd0, hex3}, 32'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        run_conv("post_reset512", 7'h7F, 7'h12, 7'h79, 7'h24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
